// File: rtl/stopwatch_scan.sv
// SS.cc stopwatch feeding a 4-digit seven-segment decoder: packed-BCD time on in_num,
// free-running digit select on c_digit, start/stop and clear from asynchronous buttons.
module stopwatch_scan #(
  parameter int TICK_DIV = 500000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [1:0]  c_digit,
  output logic [15:0] in_num,
  output logic        running,
  output logic        wrap
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0][3:0] DMAX = {4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nx;

  // bit 0 = start/stop, bit 1 = clear; flops reset high so a held button gives no event
  logic [1:0] btn, s1, s2, prev, ev;
  logic       ss_ev, clr_ev;

  assign btn = {btn_clr, btn_ss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '1;
      s2   <= '1;
      prev <= '1;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign ev     = s2 & ~prev;
  assign ss_ev  = ev[0];
  assign clr_ev = ev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ss_ev) state_nx = RUN;
      RUN:     if (ss_ev) state_nx = PAUSE;
      PAUSE: begin
        if (clr_ev)     state_nx = IDLE;
        else if (ss_ev) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // the prescaler only advances on cycles that stay in RUN, so the stop edge keeps the phase
  logic [TW-1:0] presc;
  logic          advance, tick;

  assign advance = (state == RUN) && !ss_ev;
  assign tick    = advance && (presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                presc <= '0;
    else if (state_nx == IDLE) presc <= '0;
    else if (advance)          presc <= tick ? '0 : presc + 1'b1;
  end

  logic [3:0][3:0] dig, dig_nx;
  logic            carry;

  always_comb begin
    dig_nx = dig;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (dig[i] == DMAX[i]) dig_nx[i] = 4'd0;
        else begin
          dig_nx[i] = dig[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig     <= '0;
      wrap    <= 1'b0;
      running <= 1'b0;
    end else begin
      wrap    <= tick && (dig == 16'h5999);
      running <= (state_nx == RUN);
      if (state_nx == IDLE) dig <= '0;
      else if (tick)        dig <= dig_nx;
    end
  end

  assign in_num = dig;

  logic [SW-1:0] scan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan    <= '0;
      c_digit <= 2'd0;
    end else if (scan == SCAN_LAST) begin
      scan    <= '0;
      c_digit <= c_digit + 2'd1;
    end else begin
      scan    <= scan + 1'b1;
    end
  end
endmodule

// File: tb/tb_stopwatch_scan.sv
// Bench for stopwatch_scan: directed vector table, carry/wrap/reset sequences and random
// buttons, all compared against an elapsed-cycle reference model.
module tb_stopwatch_scan;
  localparam int TD = 4;
  localparam int SD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [1:0]  c_digit;
  logic [15:0] in_num;
  logic        running;
  logic        wrap;

  stopwatch_scan #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .c_digit(c_digit), .in_num(in_num), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: state 0/1/2 = idle/run/pause, m_run = edges spent counting,
  // m_cyc = edges since reset release, h_* = button samples (bit 0 newest)
  int       m_st, m_run, m_cyc;
  bit       m_wrap;
  bit [2:0] h_ss, h_clr;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_run = 0; m_cyc = 0; m_wrap = 0;
    h_ss = 3'b111; h_clr = 3'b111;
  endtask

  task automatic model_edge(input bit ss, input bit clr);
    bit se, ce;
    se = h_ss[1] & ~h_ss[2];
    ce = h_clr[1] & ~h_clr[2];
    h_ss  = {h_ss[1:0], ss};
    h_clr = {h_clr[1:0], clr};
    m_cyc++;
    m_wrap = 0;
    case (m_st)
      0: if (se) m_st = 1;
      1: if (se) m_st = 2;
         else begin
           m_run++;
           if (m_run % (TD * 6000) == 0) m_wrap = 1;
         end
      default: if (ce) begin m_st = 0; m_run = 0; end
               else if (se) m_st = 1;
    endcase
  endtask

  task automatic compare_model();
    check("in_num", in_num, bcd((m_run / TD) % 6000));
    check("running", 16'(running), 16'(m_st == 1));
    check("wrap", 16'(wrap), 16'(m_wrap));
    check("c_digit", 16'(c_digit), 16'((m_cyc / SD) % 4));
  endtask

  task automatic step(input bit ss, input bit clr);
    btn_ss = ss; btn_clr = clr;
    @(posedge clk);
    model_edge(ss, clr);
    #1;
    compare_model();
  endtask

  task automatic async_reset(input bit hold_ss);
    #2;
    rst_n = 1'b0;
    btn_ss = hold_ss;
    model_reset();
    #1;
    check("rst_in_num", in_num, 16'h0000);
    check("rst_running", 16'(running), 16'h0);
    check("rst_wrap", 16'(wrap), 16'h0);
    check("rst_c_digit", 16'(c_digit), 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run_until(input logic [15:0] target, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step(0, 0);
      if (in_num == target) hit = 1;
    end
    n_chk++;
    if (hit) n_pass++;
    else $display("FAIL run_until: in_num %h never reached %h", in_num, target);
  endtask

  task automatic carry_check(input logic [15:0] from, input logic [15:0] to);
    run_until(from, 30000);
    repeat (TD - 1) step(0, 0);
    check("carry_hold", in_num, from);
    step(0, 0);
    check("carry_next", in_num, to);
  endtask

  typedef struct {
    bit          ss;
    bit          clr;
    int          cyc;
    logic [15:0] num;
    bit          run;
  } vec_t;
  vec_t vecs[$];

  initial begin
    bit ss_l, clr_l;
    model_reset();
    #1;
    check("init_in_num", in_num, 16'h0000);
    check("init_running", 16'(running), 16'h0);
    check("init_wrap", 16'(wrap), 16'h0);
    check("init_c_digit", 16'(c_digit), 16'h0);
    @(posedge clk); @(posedge clk);
    #2;
    rst_n = 1'b1;

    // start, pause/resume with phase kept, clear, and simultaneous-button cases
    vecs.push_back('{0, 0,  4, 16'h0000, 0});
    vecs.push_back('{1, 0,  1, 16'h0000, 0});
    vecs.push_back('{0, 0,  2, 16'h0000, 1});
    vecs.push_back('{0, 0,  3, 16'h0000, 1});
    vecs.push_back('{0, 0,  1, 16'h0001, 1});
    vecs.push_back('{0, 0,  4, 16'h0002, 1});
    vecs.push_back('{0, 0,  4, 16'h0003, 1});
    vecs.push_back('{0, 0, 36, 16'h0012, 1});
    vecs.push_back('{1, 0,  1, 16'h0012, 1});
    vecs.push_back('{0, 0,  2, 16'h0012, 0});
    vecs.push_back('{0, 0, 20, 16'h0012, 0});
    vecs.push_back('{1, 0,  1, 16'h0012, 0});
    vecs.push_back('{0, 0,  2, 16'h0012, 1});
    vecs.push_back('{0, 0,  1, 16'h0012, 1});
    vecs.push_back('{0, 0,  1, 16'h0013, 1});
    vecs.push_back('{1, 0,  1, 16'h0013, 1});
    vecs.push_back('{0, 0,  2, 16'h0013, 0});
    vecs.push_back('{0, 1,  1, 16'h0013, 0});
    vecs.push_back('{0, 0,  2, 16'h0000, 0});
    vecs.push_back('{1, 1,  1, 16'h0000, 0});
    vecs.push_back('{0, 0,  2, 16'h0000, 1});
    vecs.push_back('{0, 1,  1, 16'h0000, 1});
    vecs.push_back('{0, 0,  2, 16'h0000, 1});
    vecs.push_back('{1, 1,  1, 16'h0001, 1});
    vecs.push_back('{0, 0,  2, 16'h0001, 0});
    vecs.push_back('{1, 1,  1, 16'h0001, 0});
    vecs.push_back('{0, 0,  2, 16'h0000, 0});

    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].cyc; c++) step(vecs[k].ss, vecs[k].clr);
      check($sformatf("vec%0d_num", k), in_num, vecs[k].num);
      check($sformatf("vec%0d_run", k), 16'(running), 16'(vecs[k].run));
    end

    // carry chain through every digit and the 59.99 wrap
    step(1, 0);
    carry_check(16'h0009, 16'h0010);
    carry_check(16'h0099, 16'h0100);
    carry_check(16'h0999, 16'h1000);
    carry_check(16'h5999, 16'h0000);
    check("wrap_hi", 16'(wrap), 16'h1);
    step(0, 0);
    check("wrap_lo", 16'(wrap), 16'h0);
    check("wrap_num", in_num, 16'h0000);
    repeat (TD - 1) step(0, 0);
    check("after_wrap", in_num, 16'h0001);

    // asynchronous reset mid-count, released with start/stop held
    run_until(16'h0345, 2000);
    async_reset(1);
    repeat (6) step(1, 0);
    check("held_ss_idle", 16'(running), 16'h0);
    repeat (3) step(0, 0);
    step(1, 0);
    repeat (3) step(0, 0);
    check("post_rst_start", 16'(running), 16'h1);

    ss_l = 0; clr_l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ss_l = ~ss_l;
      if ($urandom_range(0, 11) == 0) clr_l = ~clr_l;
      if ($urandom_range(0, 599) == 0) async_reset(ss_l);
      step(ss_l, clr_l);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
